irq_vector_ctrl: RTL and testbench
==================================

// Module: irq_vector_ctrl
// PURPOSE
//  Parametrised, clocked interrupt controller feeding the single-cycle core's PC mux.
//  - Captures rising edges on N_IRQ request lines into sticky pending bits, masks them and
//    picks the highest-priority channel.
//  - Presents the chosen channel's ISR vector with a req/ack handshake, then holds off new
//    requests until the core signals ISR completion.
// PARAMETERS
//  N_IRQ       8              number of interrupt channels (2..32)
//  XLEN        32             width of pc_isr
//  VEC_BASE    32'h0000_0000  ISR address of channel 0
//  VEC_STRIDE  32'h0000_0015  address distance between consecutive channel vectors
// PORTS
//  clk        in   1       core clock, all logic on posedge
//  rst_n      in   1       synchronous active-low reset
//  irq_in     in   N_IRQ   raw request lines, rising-edge sensitive
//  irq_mask   in   N_IRQ   1 = channel enabled; masked channels still latch pending
//  irq_ack    in   1       core has taken the vector (PC loaded with pc_isr)
//  irq_done   in   1       core finished the ISR (return-from-interrupt), 1-cycle pulse
//  irq_req    out  1       vector valid, request to core
//  irq_id     out  IDW     channel being requested/serviced, IDW = $clog2(N_IRQ)
//  pc_isr     out  XLEN    VEC_BASE + irq_id*VEC_STRIDE, truncated to XLEN
//  pending    out  N_IRQ   sticky pending bits (status)
//  in_service out  1       high from ack until done
// BEHAVIOUR
//  - Reset (rst_n low at posedge): pending=0, edge history=0, irq_req=0, irq_id=0,
//    pc_isr=VEC_BASE, in_service=0, FSM=IDLE. Aborts any transaction in progress.
//  - Edge detect: prev <= irq_in each cycle; rise = irq_in & ~prev; pending |= rise.
//  - FSM IDLE: if |(pending & irq_mask), register winner (lowest index wins), irq_id,
//    pc_isr; assert irq_req next cycle; go REQ.
//    Edge sampled at posedge t -> pending at t+1 -> irq_req at t+2.
//  - FSM REQ: irq_req, irq_id, pc_isr held stable until irq_ack (no re-arbitration, even
//    if a higher-priority edge arrives). On irq_ack: clear pending[irq_id], drop irq_req,
//    in_service=1, go SERV.
//  - FSM SERV: irq_req stays 0. On irq_done: in_service=0, go IDLE; arbitration may
//    re-raise irq_req 1 cycle later.
//  - Simultaneous new edge on irq_id with ack: set wins, channel stays pending.
//  - Mask dropped while in REQ: request is still honoured (no retraction).
//  - irq_ack outside REQ and irq_done outside SERV: ignored.
//  - Line held high: one pending event only; a new edge needs a low cycle first.
//  - Events while pending is already set coalesce into one.
// CONFIGURATION
//  IRQ_SYNC_EN defined: each irq_in passes a 2-flop synchroniser (reset to 0) before edge
//    detect; latency edge->irq_req = 4 cycles.
//  Not defined: irq_in must be synchronous to clk; latency = 2 cycles.
// STRUCTURE
//  - Shared package irq_pkg: FSM state enum (IDLE, REQ, SERV) and the
//    IRQ_VEC_BASE/IRQ_VEC_STRIDE defaults.
//  - One sub-module, irq_prio_enc: N_IRQ-wide fixed-priority encoder (valid + index).
// TESTING
//  1. irq_in[3] 0->1, mask=8'hFF -> irq_req at +2 cycles, irq_id=3, pc_isr=32'h3F;
//     ack -> pending[3]=0.
//  2. Edges on ch5 and ch1 in the same cycle -> ch1 served first (pc_isr=32'h15);
//     after done, ch5 served (pc_isr=32'h69).
//  3. Edge on ch2 with mask[2]=0 -> no irq_req, pending[2]=1;
//     set mask[2]=1 -> irq_req 1 cycle later, irq_id=2.
//  4. During SERV of ch0, edge on ch0 -> pending[0]=1, no irq_req until irq_done;
//     then ch0 is re-requested.
//  5. rst_n=0 in REQ and in SERV -> next cycle all outputs at reset values;
//     stale edges not replayed.
//  6. With IRQ_SYNC_EN: latency edge->irq_req = 4 cycles; ack/done ignored outside
//     REQ/SERV.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt vector controller:
// FSM state encoding, default vector table placement and the vector address helper.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } irq_state_e;

  localparam logic [31:0] IRQ_VEC_BASE   = 32'h0000_0000;
  localparam logic [31:0] IRQ_VEC_STRIDE = 32'h0000_0015;

  // Full-width product; callers truncate to their own address width.
  function automatic logic [63:0] irq_vec_addr(input logic [31:0] base,
                                               input logic [31:0] stride,
                                               input logic [31:0] idx);
    return {32'd0, base} + ({32'd0, idx} * {32'd0, stride});
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the index of the
// lowest-numbered set bit.
module irq_prio_enc #(
  parameter  int N   = 8,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  output logic           o_valid,
  output logic [IDW-1:0] o_idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/irq_vector_ctrl.sv
// Interrupt controller: edge-captured sticky pending bits, masked lowest-index arbitration,
// req/ack vector handshake held off until ISR completion. Optional macro IRQ_SYNC_EN.
module irq_vector_ctrl
  import irq_pkg::*;
#(
  parameter  int          N_IRQ      = 8,
  parameter  int          XLEN       = 32,
  parameter  logic [31:0] VEC_BASE   = IRQ_VEC_BASE,
  parameter  logic [31:0] VEC_STRIDE = IRQ_VEC_STRIDE,
  localparam int          IDW        = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             irq_ack,
  input  logic             irq_done,
  output logic             irq_req,
  output logic [IDW-1:0]   irq_id,
  output logic [XLEN-1:0]  pc_isr,
  output logic [N_IRQ-1:0] pending,
  output logic             in_service
);

  irq_state_e       r_state;
  irq_state_e       w_state_next;
  logic [N_IRQ-1:0] w_line;
  logic [N_IRQ-1:0] r_prev;
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] w_clr;
  logic [N_IRQ-1:0] w_cand;
  logic             w_win_valid;
  logic [IDW-1:0]   w_win_idx;
  logic [IDW-1:0]   r_irq_id;
  logic [XLEN-1:0]  r_pc_isr;
  logic             w_grant;
  logic             w_take;

`ifdef IRQ_SYNC_EN
  logic [N_IRQ-1:0] r_sync1;
  logic [N_IRQ-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_line = r_sync2;
`else
  assign w_line = irq_in;
`endif

  assign w_rise = w_line & ~r_prev;
  assign w_cand = r_pending & irq_mask;
  // A rise on the acknowledged channel in the ack cycle re-sets the bit after the clear.
  assign w_clr  = w_take ? ({{(N_IRQ-1){1'b0}}, 1'b1} << r_irq_id) : '0;

  irq_prio_enc #(
    .N(N_IRQ)
  ) u_prio_enc (
    .i_req  (w_cand),
    .o_valid(w_win_valid),
    .o_idx  (w_win_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_win_valid) w_state_next = REQ;
      REQ:     if (irq_ack)     w_state_next = SERV;
      SERV:    if (irq_done)    w_state_next = IDLE;
      default:                  w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_grant    = 1'b0;
    w_take     = 1'b0;
    irq_req    = 1'b0;
    in_service = 1'b0;
    case (r_state)
      IDLE: w_grant = w_win_valid;
      REQ: begin
        irq_req = 1'b1;
        w_take  = irq_ack;
      end
      SERV:    in_service = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev    <= '0;
      r_pending <= '0;
      r_irq_id  <= '0;
      r_pc_isr  <= XLEN'(VEC_BASE);
    end else begin
      r_prev    <= w_line;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      // Winner is latched only on entry to REQ; it stays frozen through REQ and SERV.
      if (w_grant) begin
        r_irq_id <= w_win_idx;
        r_pc_isr <= XLEN'(irq_vec_addr(VEC_BASE, VEC_STRIDE, 32'(w_win_idx)));
      end
    end
  end

  assign irq_id  = r_irq_id;
  assign pc_isr  = r_pc_isr;
  assign pending = r_pending;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Self-checking bench for irq_vector_ctrl: directed scenarios plus randomized traffic,
// checked against a transaction-level reference model and a request scoreboard.
module tb_irq_vector_ctrl;

  localparam int          N   = 8;
  localparam logic [31:0] VB  = 32'h0000_0000;
  localparam logic [31:0] VS  = 32'h0000_0015;
`ifdef IRQ_SYNC_EN
  localparam int          LAT = 4;
`else
  localparam int          LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] irq_in;
  logic [N-1:0] irq_mask;
  logic         irq_ack;
  logic         irq_done;
  logic         irq_req;
  logic [2:0]   irq_id;
  logic [31:0]  pc_isr;
  logic [N-1:0] pending;
  logic         in_service;

  irq_vector_ctrl #(
    .N_IRQ(N), .XLEN(32), .VEC_BASE(VB), .VEC_STRIDE(VS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .irq_mask(irq_mask),
    .irq_ack(irq_ack), .irq_done(irq_done), .irq_req(irq_req), .irq_id(irq_id),
    .pc_isr(pc_isr), .pending(pending), .in_service(in_service)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          id;
    logic [31:0] pc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: which channel (if any) is requesting or being serviced.
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_prev = '0;
  logic [N-1:0] m_s1   = '0;
  logic [N-1:0] m_s2   = '0;
  bit           m_req  = 1'b0;
  bit           m_serv = 1'b0;
  int           m_id   = 0;
  logic [31:0]  m_pc   = VB;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [N-1:0] line;
    logic [N-1:0] rise;
    logic [N-1:0] cand;
    if (!rst_n) begin
      m_pend = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
      m_req = 1'b0; m_serv = 1'b0; m_id = 0; m_pc = VB;
    end else begin
`ifdef IRQ_SYNC_EN
      line = m_s2;
      m_s2 = m_s1;
      m_s1 = irq_in;
`else
      line = irq_in;
`endif
      rise   = line & ~m_prev;
      m_prev = line;
      cand   = m_pend & irq_mask;
      if (m_req) begin
        if (irq_ack) begin
          m_pend[m_id] = 1'b0;
          m_req  = 1'b0;
          m_serv = 1'b1;
        end
      end else if (m_serv) begin
        if (irq_done) m_serv = 1'b0;
      end else if (cand != 0) begin
        for (int i = 0; i < N; i++) begin
          if (cand[i]) begin
            m_id = i;
            break;
          end
        end
        m_pc  = VB + 32'(m_id) * VS;
        m_req = 1'b1;
        exp_q.push_back('{id: m_id, pc: m_pc});
      end
      m_pend = m_pend | rise;
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_step();
    end
    #1;
  endtask

  task automatic serve();
    irq_ack = 1'b1;
    tick();
    irq_ack  = 1'b0;
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
  endtask

  // Monitor: per-cycle status vs model, and one scoreboard pop per new request.
  initial begin
    bit prev_req = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      chk("mon_req", irq_req, m_req);
      chk("mon_in_service", in_service, m_serv);
      chk("mon_pending", pending, m_pend);
      chk("mon_id", irq_id, m_id);
      chk("mon_pc", pc_isr, m_pc);
      if (irq_req === 1'b1 && !prev_req) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_req", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_id", irq_id, e.id);
          chk("sb_pc", pc_isr, e.pc);
          $display("req id=%0d pc=%08h expected id=%0d pc=%08h", irq_id, pc_isr, e.id, e.pc);
        end
      end
      prev_req = (irq_req === 1'b1);
    end
  end

  initial begin
    rst_n = 1'b0; irq_in = '0; irq_mask = '1; irq_ack = 1'b0; irq_done = 1'b0;
    tick(2);
    chk("rst_req", irq_req, 0);
    chk("rst_pc", pc_isr, VB);
    chk("rst_pending", pending, 0);
    rst_n = 1'b1;
    tick(2);

    // Single edge on ch3
    irq_in = 8'h08;
    tick(LAT - 1);
    chk("t1_no_req_early", irq_req, 0);
    tick();
    chk("t1_req", irq_req, 1);
    chk("t1_id", irq_id, 3);
    chk("t1_pc", pc_isr, 32'h3F);
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    chk("t1_done_ignored_in_req", irq_req, 1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("t1_pending_clr", pending, 0);
    chk("t1_in_service", in_service, 1);
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    irq_in = '0;
    tick(4);

    // Simultaneous ch5 and ch1: ch1 first
    irq_in = 8'h22;
    tick(LAT);
    chk("t2_id_first", irq_id, 1);
    chk("t2_pc_first", pc_isr, 32'h15);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("t2_pending_left", pending, 8'h20);
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    chk("t2_gap_after_done", irq_req, 0);
    tick();
    chk("t2_id_second", irq_id, 5);
    chk("t2_pc_second", pc_isr, 32'h69);
    serve();
    irq_in = '0;
    tick(4);

    // Masked channel still latches; unmask raises request one cycle later
    irq_mask = 8'hFB;
    irq_in   = 8'h04;
    tick(LAT + 2);
    chk("t3_masked_no_req", irq_req, 0);
    chk("t3_masked_pending", pending, 8'h04);
    irq_mask = 8'hFF;
    tick();
    chk("t3_unmask_req", irq_req, 1);
    chk("t3_unmask_id", irq_id, 2);
    serve();
    irq_in = '0;
    tick(4);

    // Re-edge on ch0 during its own service
    irq_in = 8'h01;
    tick(LAT);
    chk("t4_req", irq_req, 1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_in  = '0;
    tick(2);
    irq_in = 8'h01;
    tick(LAT);
    chk("t4_pending_in_serv", pending, 8'h01);
    chk("t4_no_req_in_serv", irq_req, 0);
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    chk("t4_no_req_same_cycle", irq_req, 0);
    tick();
    chk("t4_rereq", irq_req, 1);
    chk("t4_rereq_id", irq_id, 0);
    serve();
    irq_in = '0;
    tick(4);

    // Reset in REQ, then in SERV
    irq_in = 8'h10;
    tick(LAT);
    chk("t5_req_before_rst", irq_req, 1);
    irq_in = '0;
    rst_n  = 1'b0;
    tick();
    chk("t5_rst_req", irq_req, 0);
    chk("t5_rst_id", irq_id, 0);
    chk("t5_rst_pc", pc_isr, VB);
    rst_n = 1'b1;
    tick(6);
    chk("t5_no_replay", irq_req, 0);
    irq_in = 8'h10;
    tick(LAT);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("t5_serv_before_rst", in_service, 1);
    irq_in = '0;
    rst_n  = 1'b0;
    tick();
    chk("t5_rst_in_service", in_service, 0);
    rst_n = 1'b1;
    tick(6);
    chk("t5_no_replay_serv", pending, 0);

    // ack/done in IDLE are ignored
    irq_ack  = 1'b1;
    irq_done = 1'b1;
    tick();
    irq_ack  = 1'b0;
    irq_done = 1'b0;
    chk("t6_idle_req", irq_req, 0);
    chk("t6_idle_in_service", in_service, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] flip;
      flip     = N'($urandom) & N'($urandom) & N'($urandom);
      irq_in   = irq_in ^ flip;
      irq_mask = ~(N'($urandom) & N'($urandom) & N'($urandom));
      irq_ack  = ($urandom_range(0, 2) == 0);
      irq_done = ($urandom_range(0, 3) == 0);
      rst_n    = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1; irq_ack = 1'b0; irq_done = 1'b0;
    tick(2);
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
